// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scanner for NUM_PAIRS two-digit values on one shared 7-segment bus.
// Drives an external binary-to-two-digit converter and adds anti-ghost blanking, leading-zero suppression and blink.
module display_scan_ctrl #(
   parameter int          NUM_PAIRS    = 2,
   parameter int          ON_CYC       = 4000,
   parameter int          BLANK_CYC    = 100,
   parameter int          BLINK_FRAMES = 50,
   parameter logic [6:0]  SEG_BLANK    = 7'h7F
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     load,
   input  logic [7*NUM_PAIRS-1:0]   vals,
   input  logic [NUM_PAIRS-1:0]     blinkEn,
   input  logic                     lzSuppress,
   output logic [6:0]               cvtVal,
   input  logic [6:0]               cvtLo,
   input  logic [6:0]               cvtHi,
   output logic [6:0]               seg,
   output logic [2*NUM_PAIRS-1:0]   an,
   output logic                     frame
);

   localparam int NUM_DIG = 2 * NUM_PAIRS;
   localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
   localparam int PAIR_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
   localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);
   localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [NUM_DIG-1:0] AN_OFF   = '1;

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [IDX_W-1:0]     idx, idx_d;
   logic [BLK_W-1:0]     blink_cnt, blink_cnt_d;
   logic                 blink_phase, blink_phase_d;
   logic [6:0]           seg_d;
   logic [NUM_DIG-1:0]   an_d;
   logic                 frame_d;

   logic [6:0]           shadow [NUM_PAIRS];
   logic [PAIR_W-1:0]    pair;
   logic [6:0]           cur_val;
   logic [6:0]           sat_val;
   logic                 dark;

   // NOTE: the shadow file is reset explicitly because the scanner reads it right out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int p = 0; p < NUM_PAIRS; p++) shadow[p] <= '0;
      end else if (load) begin
         for (int p = 0; p < NUM_PAIRS; p++) shadow[p] <= vals[7*p +: 7];
      end
   end

   assign pair    = PAIR_W'(idx >> 1);
   assign cur_val = shadow[pair];
   assign sat_val = (cur_val > 7'd99) ? 7'd99 : cur_val;
   assign cvtVal  = sat_val;

   // A digit goes dark on a suppressed leading zero or during the off half of its pair's blink.
   assign dark = (lzSuppress && idx[0] && (sat_val < 7'd10)) ||
                 (blinkEn[pair] && blink_phase);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d       = state;
      cnt_d         = cnt + CNT_W'(1);
      idx_d         = idx;
      blink_cnt_d   = blink_cnt;
      blink_phase_d = blink_phase;
      seg_d         = seg;
      an_d          = an;
      frame_d       = 1'b0;
      case (state)
         ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
               if (dark) begin
                  seg_d = SEG_BLANK;
                  an_d  = AN_OFF;
               end else begin
                  seg_d = idx[0] ? cvtHi : cvtLo;
                  an_d  = ~(NUM_DIG'(1) << idx);
               end
            end
         end
         ST_SHOW: begin
            if (cnt == ON_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               seg_d   = SEG_BLANK;
               an_d    = AN_OFF;
               if (idx == IDX_LAST) begin
                  idx_d   = '0;
                  frame_d = 1'b1;
                  if (blink_cnt == BLK_LAST) begin
                     blink_cnt_d   = '0;
                     blink_phase_d = ~blink_phase;
                  end else begin
                     blink_cnt_d = blink_cnt + BLK_W'(1);
                  end
               end else begin
                  idx_d = idx + IDX_W'(1);
               end
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_BLANK;
         cnt         <= '0;
         idx         <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         seg         <= SEG_BLANK;
         an          <= AN_OFF;
         frame       <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         idx         <= idx_d;
         blink_cnt   <= blink_cnt_d;
         blink_phase <= blink_phase_d;
         seg         <= seg_d;
         an          <= an_d;
         frame       <= frame_d;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a timeline model derived from edge counts since reset,
// checked every cycle, plus hand-computed literal expectations for the documented scenarios.
module tb_display_scan_ctrl;

   localparam int NP     = 2;
   localparam int ON     = 4;
   localparam int BLK    = 2;
   localparam int BF     = 2;
   localparam int SLOT   = ON + BLK;
   localparam int SCAN   = SLOT * 2 * NP;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
   } disp_t;

   localparam disp_t DARK = '{an: 4'hF, seg: 7'h7F};

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        load = 1'b0;
   logic [13:0] vals = '0;
   logic [1:0]  blinkEn = '0;
   logic        lzSuppress = 1'b0;
   logic [6:0]  cvtVal, cvtLo, cvtHi, seg;
   logic [3:0]  an;
   logic        frame;

   int n_checks = 0;
   int n_err    = 0;

   int    m_t   = 0;
   int    m_sh0 = 0;
   int    m_sh1 = 0;
   disp_t exp_d = DARK;
   logic  exp_frame = 1'b0;
   int    exp_cvt = 0;

   display_scan_ctrl #(
      .NUM_PAIRS(NP), .ON_CYC(ON), .BLANK_CYC(BLK), .BLINK_FRAMES(BF), .SEG_BLANK(7'h7F)
   ) dut (
      .clk(clk), .rstn(rstn), .load(load), .vals(vals), .blinkEn(blinkEn),
      .lzSuppress(lzSuppress), .cvtVal(cvtVal), .cvtLo(cvtLo), .cvtHi(cvtHi),
      .seg(seg), .an(an), .frame(frame)
   );

   always #5 clk = ~clk;

   // Active-low gfedcba digit patterns used by the stand-in converter.
   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  default: return 7'h10;
      endcase
   endfunction

   function automatic int sat(input int v);
      return (v > 99) ? 99 : v;
   endfunction

   assign cvtLo = pat(int'(cvtVal) % 10);
   assign cvtHi = pat(int'(cvtVal) / 10);

   // Display after edge t: lit slots start at t = BLK + k*SLOT, go dark at multiples of SLOT.
   function automatic disp_t disp_next(input int t, input disp_t prev, input int s0, input int s1,
                                       input logic lz, input logic [1:0] ben);
      disp_t r;
      int k, d, v, f;
      logic dk;
      r = prev;
      if (t % SLOT == BLK) begin
         k  = (t - BLK) / SLOT;
         d  = k % (2 * NP);
         v  = sat((d / 2 == 0) ? s0 : s1);
         f  = k / (2 * NP);
         dk = (lz && (d % 2 == 1) && (v < 10)) || (ben[d / 2] && ((f / BF) % 2 == 1));
         if (dk) begin
            r = DARK;
         end else begin
            r.an  = ~(4'b0001 << d);
            r.seg = pat((d % 2 == 1) ? v / 10 : v % 10);
         end
      end else if (t % SLOT == 0) begin
         r = DARK;
      end
      return r;
   endfunction

   function automatic int cvt_exp(input int t, input int s0, input int s1);
      int d;
      d = (t / SLOT) % (2 * NP);
      return sat((d / 2 == 0) ? s0 : s1);
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_t       <= 0;
         m_sh0     <= 0;
         m_sh1     <= 0;
         exp_d     <= DARK;
         exp_frame <= 1'b0;
         exp_cvt   <= 0;
      end else begin
         m_t <= m_t + 1;
         if (load) begin
            m_sh0 <= int'(vals[6:0]);
            m_sh1 <= int'(vals[13:7]);
         end
         exp_d     <= disp_next(m_t + 1, exp_d, m_sh0, m_sh1, lzSuppress, blinkEn);
         exp_frame <= ((m_t + 1) % SCAN == 0);
         exp_cvt   <= cvt_exp(m_t + 1, load ? int'(vals[6:0]) : m_sh0,
                              load ? int'(vals[13:7]) : m_sh1);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d got=%h want=%h", name, m_t, act, exp);
      end
   endtask

   task automatic wait_t(input int target);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 3 * SCAN && !hit; i++) begin
         @(negedge clk);
         hit = (m_t % SCAN == target);
      end
      if (!hit) begin
         n_checks++;
         n_err++;
         $display("FAIL timeout waiting for scan position %0d", target);
      end
   endtask

   task automatic wait_abs(input int target);
      for (int i = 0; i < 8 * SCAN && m_t != target; i++) @(negedge clk);
      check("reach_abs_t", 32'(m_t), 32'(target));
   endtask

   task automatic pulse_load(input int p0, input int p1);
      vals = {7'(p1), 7'(p0)};
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            check("mdl_an",    32'(an),     32'(exp_d.an));
            check("mdl_seg",   32'(seg),    32'(exp_d.seg));
            check("mdl_frame", 32'(frame),  32'(exp_frame));
            check("mdl_cvt",   32'(cvtVal), 32'(exp_cvt));
         end
      join_none

      // Reset and scan order.
      #1 rstn = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_frame", 32'(frame), 32'h0);
      vals = {7'd42, 7'd7};
      #2 rstn = 1'b1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("t1_dark", 32'(an), 32'hF);
      @(negedge clk);
      check("d0_an", 32'(an), 32'hE);
      check("d0_seg", 32'(seg), 32'h78);
      repeat (SLOT) @(negedge clk);
      check("d1_an", 32'(an), 32'hD);
      check("d1_seg", 32'(seg), 32'h40);
      repeat (SLOT) @(negedge clk);
      check("d2_an", 32'(an), 32'hB);
      check("d2_seg", 32'(seg), 32'h24);
      repeat (SLOT) @(negedge clk);
      check("d3_an", 32'(an), 32'h7);
      check("d3_seg", 32'(seg), 32'h19);
      repeat (3) @(negedge clk);
      check("frame_pre", 32'(frame), 32'h0);
      @(negedge clk);
      check("frame_pulse", 32'(frame), 32'h1);
      @(negedge clk);
      check("frame_post", 32'(frame), 32'h0);

      // Leading-zero suppression.
      lzSuppress = 1'b1;
      wait_t(8);
      check("lz_d1_an", 32'(an), 32'hF);
      check("lz_d1_seg", 32'(seg), 32'h7F);
      wait_t(20);
      check("lz_d3_an", 32'(an), 32'h7);
      check("lz_d3_seg", 32'(seg), 32'h19);
      pulse_load(0, 42);
      wait_t(2);
      check("lz0_d0_an", 32'(an), 32'hE);
      check("lz0_d0_seg", 32'(seg), 32'h40);
      wait_t(8);
      check("lz0_d1_an", 32'(an), 32'hF);

      // Saturation.
      lzSuppress = 1'b0;
      pulse_load(120, 42);
      wait_t(2);
      check("sat_cvt", 32'(cvtVal), 32'd99);
      check("sat_d0_seg", 32'(seg), 32'h10);
      wait_t(8);
      check("sat_d1_seg", 32'(seg), 32'h10);
      wait_t(14);
      check("sat_d2_seg", 32'(seg), 32'h24);

      // Load mid-digit, then asynchronous reset mid-digit.
      wait_t(3);
      pulse_load(55, 42);
      check("mid_cvt", 32'(cvtVal), 32'd55);
      check("mid_seg_hold", 32'(seg), 32'h10);
      @(negedge clk);
      check("mid_seg_hold2", 32'(seg), 32'h10);
      wait_t(8);
      check("mid_d1_seg", 32'(seg), 32'h12);
      wait_t(3);
      #2 rstn = 1'b0;
      #1;
      check("async_an", 32'(an), 32'hF);
      check("async_seg", 32'(seg), 32'h7F);
      @(negedge clk);

      // Blink from a fresh reset.
      vals = {7'd42, 7'd7};
      blinkEn = 2'b10;
      #2 rstn = 1'b1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      check("rst2_d0_an", 32'(an), 32'hE);
      check("rst2_d0_seg", 32'(seg), 32'h78);
      wait_abs(14);
      check("blk_f0_d2", 32'(an), 32'hB);
      wait_abs(50);
      check("blk_f2_d0_an", 32'(an), 32'hE);
      check("blk_f2_d0_seg", 32'(seg), 32'h78);
      wait_abs(62);
      check("blk_f2_d2", 32'(an), 32'hF);
      wait_abs(68);
      check("blk_f2_d3", 32'(an), 32'hF);
      wait_abs(110);
      check("blk_f4_d2", 32'(an), 32'hB);

      // Randomized run against the timeline model.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         load = ($urandom_range(0, 7) == 0);
         vals = {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
         if ($urandom_range(0, 49) == 0) lzSuppress = ~lzSuppress;
         if ($urandom_range(0, 99) == 0) blinkEn = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
